// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: functional-unit encoding and the
// entry, wakeup and issue record layouts used around the reservation station.
package ooo_pkg;

    localparam int ROB_SIZE_BITS = 4;
    localparam int TAG_W         = 6;
    localparam int PAYLOAD_W     = 64;

    localparam logic [1:0] FU_ALU = 2'b00;
    localparam logic [1:0] FU_MEM = 2'b01;

    typedef struct packed {
        logic                     valid;
        logic                     src1_rdy;
        logic                     src2_rdy;
        logic [TAG_W-1:0]         src1_tag;
        logic [TAG_W-1:0]         src2_tag;
        logic [1:0]               fu;
        logic [ROB_SIZE_BITS-1:0] rob;
        logic [PAYLOAD_W-1:0]     payload;
    } rs_entry_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } wakeup_t;

    typedef struct packed {
        logic                     valid;
        logic [ROB_SIZE_BITS-1:0] rob;
        logic [TAG_W-1:0]         src1_tag;
        logic [TAG_W-1:0]         src2_tag;
        logic [PAYLOAD_W-1:0]     payload;
    } issue_t;

endpackage

// File: rtl/rs_pick_n.sv
// N-of-M lowest-index priority picker: grant k is the k-th lowest set request
// bit, one-hot (or zero when fewer than k+1 requests are present).
module rs_pick_n #(
    parameter int N = 1,
    parameter int M = 4
) (
    input  logic [M-1:0]        i_req,
    output logic [N-1:0][M-1:0] o_grant
);

    logic [N-1:0][M-1:0] w_rem;

    assign w_rem[0] = i_req;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            // x & -x isolates the lowest set bit
            assign o_grant[gi] = w_rem[gi] & (~w_rem[gi] + M'(1));
            if (gi < N - 1) begin : g_next
                assign w_rem[gi+1] = w_rem[gi] & ~o_grant[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: lowest-free-entry allocation, tag wakeup with
// dispatch bypass, and lowest-index selection onto NUM_ALU ALU ports and one MEM port.
module reservation_station #(
    parameter int RS_DEPTH       = 16,
    parameter int DISPATCH_WIDTH = 2,
    parameter int WAKEUP_PORTS   = 2,
    parameter int NUM_ALU        = 2,
    parameter int TAG_W          = 6,
    parameter int ROB_SIZE_BITS  = 4,
    parameter int PAYLOAD_W      = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [DISPATCH_WIDTH-1:0]           disp_valid,
    output logic                                disp_ready,
    input  logic [DISPATCH_WIDTH*TAG_W-1:0]     disp_src1_tag,
    input  logic [DISPATCH_WIDTH*TAG_W-1:0]     disp_src2_tag,
    input  logic [DISPATCH_WIDTH-1:0]           disp_src1_rdy,
    input  logic [DISPATCH_WIDTH-1:0]           disp_src2_rdy,
    input  logic [DISPATCH_WIDTH*2-1:0]         disp_fu,
    input  logic [DISPATCH_WIDTH*ROB_SIZE_BITS-1:0] disp_rob,
    input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] disp_payload,
    input  logic [WAKEUP_PORTS-1:0]             wk_valid,
    input  logic [WAKEUP_PORTS*TAG_W-1:0]       wk_tag,
    output logic [NUM_ALU-1:0]                  alu_issue_valid,
    input  logic [NUM_ALU-1:0]                  alu_issue_ready,
    output logic [NUM_ALU*ROB_SIZE_BITS-1:0]    alu_issue_rob,
    output logic [NUM_ALU*PAYLOAD_W-1:0]        alu_issue_payload,
    output logic [NUM_ALU*TAG_W-1:0]            alu_issue_src1_tag,
    output logic [NUM_ALU*TAG_W-1:0]            alu_issue_src2_tag,
    output logic                                mem_issue_valid,
    input  logic                                mem_issue_ready,
    output logic [ROB_SIZE_BITS-1:0]            mem_issue_rob,
    output logic [PAYLOAD_W-1:0]                mem_issue_payload,
    output logic [TAG_W-1:0]                    mem_issue_src1_tag,
    output logic [TAG_W-1:0]                    mem_issue_src2_tag,
    output logic [$clog2(RS_DEPTH):0]           occupancy
);

    import ooo_pkg::*;

    localparam int OCC_W = $clog2(RS_DEPTH) + 1;

    logic [RS_DEPTH-1:0]      r_valid;
    logic [RS_DEPTH-1:0]      r_s1_rdy;
    logic [RS_DEPTH-1:0]      r_s2_rdy;
    logic [TAG_W-1:0]         r_s1_tag  [RS_DEPTH];
    logic [TAG_W-1:0]         r_s2_tag  [RS_DEPTH];
    logic [1:0]               r_fu      [RS_DEPTH];
    logic [ROB_SIZE_BITS-1:0] r_rob     [RS_DEPTH];
    logic [PAYLOAD_W-1:0]     r_payload [RS_DEPTH];
    logic [OCC_W-1:0]         r_occ;

    logic [DISPATCH_WIDTH-1:0]               w_acc;
    logic [RS_DEPTH-1:0]                     w_ready, w_alu_req, w_mem_req, w_fire, w_wr_en;
    logic [RS_DEPTH-1:0]                     w_s1_rdy_in, w_s2_rdy_in, w_s1_rdy_next, w_s2_rdy_next;
    logic [TAG_W-1:0]                        w_s1_tag_in  [RS_DEPTH];
    logic [TAG_W-1:0]                        w_s2_tag_in  [RS_DEPTH];
    logic [1:0]                              w_fu_in      [RS_DEPTH];
    logic [ROB_SIZE_BITS-1:0]                w_rob_in     [RS_DEPTH];
    logic [PAYLOAD_W-1:0]                    w_payload_in [RS_DEPTH];
    logic [DISPATCH_WIDTH-1:0][RS_DEPTH-1:0] w_alloc_grant;
    logic [NUM_ALU-1:0][RS_DEPTH-1:0]        w_alu_grant;
    logic [0:0][RS_DEPTH-1:0]                w_mem_grant;
    logic [OCC_W-1:0]                        w_n_acc, w_n_iss;

    function automatic logic wk_hit(input logic [TAG_W-1:0] tag,
                                    input logic [WAKEUP_PORTS-1:0] v,
                                    input logic [WAKEUP_PORTS*TAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKEUP_PORTS; p++) begin
            if (v[p] && (t[p*TAG_W +: TAG_W] == tag) && (tag != '0)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign occupancy  = r_occ;
    assign disp_ready = (RS_DEPTH - int'(r_occ)) >= DISPATCH_WIDTH;
    assign w_acc      = disp_valid & {DISPATCH_WIDTH{disp_ready & ~flush}};

    genvar gi;
    generate
        for (gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
            // tag 0 names the hard-wired zero register and is never waited on
            assign w_ready[gi]   = r_valid[gi] & (r_s1_rdy[gi] | (r_s1_tag[gi] == '0))
                                               & (r_s2_rdy[gi] | (r_s2_tag[gi] == '0));
            assign w_alu_req[gi] = w_ready[gi] & (r_fu[gi] == FU_ALU);
            assign w_mem_req[gi] = w_ready[gi] & (r_fu[gi] == FU_MEM);
            assign w_s1_rdy_next[gi] = w_s1_rdy_in[gi] | (w_s1_tag_in[gi] == '0)
                                     | wk_hit(w_s1_tag_in[gi], wk_valid, wk_tag);
            assign w_s2_rdy_next[gi] = w_s2_rdy_in[gi] | (w_s2_tag_in[gi] == '0)
                                     | wk_hit(w_s2_tag_in[gi], wk_valid, wk_tag);
        end
    endgenerate

    rs_pick_n #(.N(DISPATCH_WIDTH), .M(RS_DEPTH)) u_alloc_pick (.i_req(~r_valid), .o_grant(w_alloc_grant));
    rs_pick_n #(.N(NUM_ALU),        .M(RS_DEPTH)) u_alu_pick   (.i_req(w_alu_req), .o_grant(w_alu_grant));
    rs_pick_n #(.N(1),              .M(RS_DEPTH)) u_mem_pick   (.i_req(w_mem_req), .o_grant(w_mem_grant));

    // The n-th accepted slot takes the n-th lowest free entry, so skipped slots leave no holes.
    always_comb begin
        int rank;
        rank    = 0;
        w_wr_en = '0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            w_s1_tag_in[e]  = r_s1_tag[e];
            w_s2_tag_in[e]  = r_s2_tag[e];
            w_s1_rdy_in[e]  = r_s1_rdy[e];
            w_s2_rdy_in[e]  = r_s2_rdy[e];
            w_fu_in[e]      = r_fu[e];
            w_rob_in[e]     = r_rob[e];
            w_payload_in[e] = r_payload[e];
        end
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (w_acc[i]) begin
                for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                    for (int e = 0; e < RS_DEPTH; e++) begin
                        if ((k == rank) && w_alloc_grant[k][e]) begin
                            w_wr_en[e]      = 1'b1;
                            w_s1_tag_in[e]  = disp_src1_tag[i*TAG_W +: TAG_W];
                            w_s2_tag_in[e]  = disp_src2_tag[i*TAG_W +: TAG_W];
                            w_s1_rdy_in[e]  = disp_src1_rdy[i];
                            w_s2_rdy_in[e]  = disp_src2_rdy[i];
                            w_fu_in[e]      = disp_fu[i*2 +: 2];
                            w_rob_in[e]     = disp_rob[i*ROB_SIZE_BITS +: ROB_SIZE_BITS];
                            w_payload_in[e] = disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
                        end
                    end
                end
                rank = rank + 1;
            end
        end
    end

    always_comb begin
        w_fire  = w_mem_grant[0] & {RS_DEPTH{mem_issue_ready}};
        w_n_acc = '0;
        w_n_iss = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            w_fire = w_fire | (w_alu_grant[k] & {RS_DEPTH{alu_issue_ready[k]}});
        end
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (w_acc[i]) w_n_acc = w_n_acc + OCC_W'(1);
        end
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (w_fire[e]) w_n_iss = w_n_iss + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= (r_valid & ~w_fire) | w_wr_en;
            r_occ   <= r_occ + w_n_acc - w_n_iss;
        end
    end

    // Entry fields are qualified by r_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        r_s1_rdy <= w_s1_rdy_next;
        r_s2_rdy <= w_s2_rdy_next;
        for (int e = 0; e < RS_DEPTH; e++) begin
            r_s1_tag[e]  <= w_s1_tag_in[e];
            r_s2_tag[e]  <= w_s2_tag_in[e];
            r_fu[e]      <= w_fu_in[e];
            r_rob[e]     <= w_rob_in[e];
            r_payload[e] <= w_payload_in[e];
        end
    end

    always_comb begin
        alu_issue_valid    = '0;
        alu_issue_rob      = '0;
        alu_issue_payload  = '0;
        alu_issue_src1_tag = '0;
        alu_issue_src2_tag = '0;
        mem_issue_valid    = |w_mem_grant[0];
        mem_issue_rob      = '0;
        mem_issue_payload  = '0;
        mem_issue_src1_tag = '0;
        mem_issue_src2_tag = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            alu_issue_valid[k] = |w_alu_grant[k];
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (w_alu_grant[k][e]) begin
                    alu_issue_rob[k*ROB_SIZE_BITS +: ROB_SIZE_BITS] = r_rob[e];
                    alu_issue_payload[k*PAYLOAD_W +: PAYLOAD_W]     = r_payload[e];
                    alu_issue_src1_tag[k*TAG_W +: TAG_W]            = r_s1_tag[e];
                    alu_issue_src2_tag[k*TAG_W +: TAG_W]            = r_s2_tag[e];
                end
            end
        end
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (w_mem_grant[0][e]) begin
                mem_issue_rob      = r_rob[e];
                mem_issue_payload  = r_payload[e];
                mem_issue_src1_tag = r_s1_tag[e];
                mem_issue_src2_tag = r_s2_tag[e];
            end
        end
    end

`ifndef SYNTHESIS
    generate
        for (gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_fu_chk
            a_fu_legal: assert property (@(posedge clk) disable iff (!rst_n)
                (disp_valid[gi] && disp_ready && !flush) |-> !disp_fu[2*gi+1]);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: table-driven dispatch/issue
// vectors plus hand-written wakeup, bypass, full, backpressure, flush and reset sequences.
module tb_reservation_station;

    localparam int DW = 2;
    localparam int TW = 6;
    localparam int RB = 4;
    localparam int PW = 64;
    localparam int NA = 2;
    localparam int WP = 2;

    logic              clk, rst_n, flush;
    logic [DW-1:0]     disp_valid;
    logic              disp_ready;
    logic [DW*TW-1:0]  disp_src1_tag, disp_src2_tag;
    logic [DW-1:0]     disp_src1_rdy, disp_src2_rdy;
    logic [DW*2-1:0]   disp_fu;
    logic [DW*RB-1:0]  disp_rob;
    logic [DW*PW-1:0]  disp_payload;
    logic [WP-1:0]     wk_valid;
    logic [WP*TW-1:0]  wk_tag;
    logic [NA-1:0]     alu_issue_valid, alu_issue_ready;
    logic [NA*RB-1:0]  alu_issue_rob;
    logic [NA*PW-1:0]  alu_issue_payload;
    logic [NA*TW-1:0]  alu_issue_src1_tag, alu_issue_src2_tag;
    logic              mem_issue_valid, mem_issue_ready;
    logic [RB-1:0]     mem_issue_rob;
    logic [PW-1:0]     mem_issue_payload;
    logic [TW-1:0]     mem_issue_src1_tag, mem_issue_src2_tag;
    logic [4:0]        occupancy;

    reservation_station dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_fu(disp_fu), .disp_rob(disp_rob), .disp_payload(disp_payload),
        .wk_valid(wk_valid), .wk_tag(wk_tag),
        .alu_issue_valid(alu_issue_valid), .alu_issue_ready(alu_issue_ready),
        .alu_issue_rob(alu_issue_rob), .alu_issue_payload(alu_issue_payload),
        .alu_issue_src1_tag(alu_issue_src1_tag), .alu_issue_src2_tag(alu_issue_src2_tag),
        .mem_issue_valid(mem_issue_valid), .mem_issue_ready(mem_issue_ready),
        .mem_issue_rob(mem_issue_rob), .mem_issue_payload(mem_issue_payload),
        .mem_issue_src1_tag(mem_issue_src1_tag), .mem_issue_src2_tag(mem_issue_src2_tag),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [RB-1:0] rob;
        logic [PW-1:0] payload;
    } exp_t;

    typedef struct {
        logic [1:0] vld;
        logic [1:0] fu0;
        logic [1:0] fu1;
        logic [3:0] rob0;
        logic [3:0] rob1;
        logic       tag0_src;
        logic [1:0] e_alu;
        logic       e_mem;
        int         e_occ;
        int         e_occ_after;
    } vec_t;

    exp_t        alu_q[$];
    exp_t        mem_q[$];
    vec_t        vecs[7];
    logic [63:0] fill_pl[16];
    logic [63:0] pl_tmp, pl_late;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        disp_valid = '0; disp_src1_tag = '0; disp_src2_tag = '0;
        disp_src1_rdy = '0; disp_src2_rdy = '0; disp_fu = '0; disp_rob = '0;
        disp_payload = '0; wk_valid = '0; wk_tag = '0; flush = 1'b0;
    endtask

    task automatic set_slot(input int s, input logic [1:0] fu, input logic [3:0] rob,
                            input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2,
                            input bit push, output logic [63:0] pl);
        pl = {$urandom, $urandom};
        disp_valid[s]            = 1'b1;
        disp_fu[s*2 +: 2]        = fu;
        disp_rob[s*RB +: RB]     = rob;
        disp_src1_tag[s*TW +: TW] = t1;
        disp_src2_tag[s*TW +: TW] = t2;
        disp_src1_rdy[s]         = r1;
        disp_src2_rdy[s]         = r2;
        disp_payload[s*PW +: PW] = pl;
        if (push) begin
            if (fu == 2'b01) mem_q.push_back('{rob, pl});
            else             alu_q.push_back('{rob, pl});
        end
    endtask

    // Compare any handshake completing at the coming edge, then advance one cycle.
    task automatic cycle();
        exp_t e;
        if (!flush) begin
            for (int k = 0; k < NA; k++) begin
                if (alu_issue_valid[k] && alu_issue_ready[k]) begin
                    if (alu_q.size() == 0) begin
                        n_total++;
                        $display("FAIL alu_issue%0d: got rob %0d expected no issue", k, alu_issue_rob[k*RB +: RB]);
                    end else begin
                        e = alu_q.pop_front();
                        check("alu_rob", 64'(alu_issue_rob[k*RB +: RB]), 64'(e.rob));
                        check("alu_payload", alu_issue_payload[k*PW +: PW], e.payload);
                    end
                end
            end
            if (mem_issue_valid && mem_issue_ready) begin
                if (mem_q.size() == 0) begin
                    n_total++;
                    $display("FAIL mem_issue: got rob %0d expected no issue", mem_issue_rob);
                end else begin
                    e = mem_q.pop_front();
                    check("mem_rob", 64'(mem_issue_rob), 64'(e.rob));
                    check("mem_payload", mem_issue_payload, e.payload);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'b11, 2'b00, 2'b00, 4'd3,  4'd4,  1'b0, 2'b11, 1'b0, 2, 0};
        vecs[1] = '{2'b11, 2'b00, 2'b01, 4'd5,  4'd6,  1'b0, 2'b01, 1'b1, 2, 0};
        vecs[2] = '{2'b11, 2'b01, 2'b00, 4'd7,  4'd8,  1'b0, 2'b01, 1'b1, 2, 0};
        vecs[3] = '{2'b11, 2'b01, 2'b01, 4'd9,  4'd10, 1'b0, 2'b00, 1'b1, 2, 1};
        vecs[4] = '{2'b11, 2'b00, 2'b00, 4'd11, 4'd12, 1'b1, 2'b11, 1'b0, 2, 0};
        vecs[5] = '{2'b10, 2'b00, 2'b00, 4'd0,  4'd13, 1'b0, 2'b01, 1'b0, 1, 0};
        vecs[6] = '{2'b10, 2'b00, 2'b01, 4'd0,  4'd14, 1'b0, 2'b00, 1'b1, 1, 0};

        rst_n = 1'b0;
        idle();
        alu_issue_ready = '0;
        mem_issue_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_occ", 64'(occupancy), 0);
        check("reset_disp_ready", 64'(disp_ready), 1);
        check("reset_alu_valid", 64'(alu_issue_valid), 0);
        check("reset_mem_valid", 64'(mem_issue_valid), 0);
        check("reset_alu_rob", 64'(alu_issue_rob), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven dispatch -> issue -> drain
        alu_issue_ready = 2'b11;
        mem_issue_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            idle();
            for (int s = 0; s < DW; s++) begin
                if (vecs[v].vld[s]) begin
                    set_slot(s, (s == 0) ? vecs[v].fu0 : vecs[v].fu1,
                             (s == 0) ? vecs[v].rob0 : vecs[v].rob1,
                             vecs[v].tag0_src ? 6'd0 : 6'd1, !vecs[v].tag0_src,
                             vecs[v].tag0_src ? 6'd0 : 6'd2, !vecs[v].tag0_src,
                             1'b1, pl_tmp);
                end
            end
            cycle();
            idle();
            check($sformatf("vec%0d_alu_valid", v), 64'(alu_issue_valid), 64'(vecs[v].e_alu));
            check($sformatf("vec%0d_mem_valid", v), 64'(mem_issue_valid), 64'(vecs[v].e_mem));
            check($sformatf("vec%0d_occ", v), 64'(occupancy), 64'(vecs[v].e_occ));
            cycle();
            check($sformatf("vec%0d_occ_after", v), 64'(occupancy), 64'(vecs[v].e_occ_after));
            for (int n = 0; n < 4 && occupancy != 0; n++) cycle();
            check($sformatf("vec%0d_drained", v), 64'(occupancy), 0);
        end

        // MEM op waits on tag 9, woken through wakeup port 1
        idle();
        set_slot(0, 2'b01, 4'd1, 6'd9, 1'b0, 6'd0, 1'b1, 1'b1, pl_tmp);
        cycle();
        idle();
        for (int h = 0; h < 5; h++) begin
            check("memwait_valid", 64'(mem_issue_valid), 0);
            cycle();
        end
        wk_valid = 2'b10;
        wk_tag   = {6'd9, 6'd0};
        check("memwake_same_cycle", 64'(mem_issue_valid), 0);
        cycle();
        idle();
        check("memwake_valid", 64'(mem_issue_valid), 1);
        check("memwake_src1_tag", 64'(mem_issue_src1_tag), 9);
        cycle();
        check("memwake_occ", 64'(occupancy), 0);

        // Dispatch-wakeup bypass on tag 12; slot 1 waits on tag 14
        idle();
        set_slot(0, 2'b00, 4'd2, 6'd0, 1'b1, 6'd12, 1'b0, 1'b1, pl_tmp);
        set_slot(1, 2'b00, 4'd3, 6'd0, 1'b1, 6'd14, 1'b0, 1'b0, pl_late);
        wk_valid = 2'b01;
        wk_tag   = {6'd0, 6'd12};
        cycle();
        idle();
        check("bypass_alu_valid", 64'(alu_issue_valid), 2'b01);
        cycle();
        check("bypass_waiting", 64'(alu_issue_valid), 0);
        alu_q.push_back('{4'd3, pl_late});
        wk_valid = 2'b01;
        wk_tag   = {6'd0, 6'd14};
        cycle();
        idle();
        check("bypass_late_valid", 64'(alu_issue_valid), 2'b01);
        cycle();
        check("bypass_occ", 64'(occupancy), 0);

        // Backpressure: entry held while the ALU refuses it
        idle();
        alu_issue_ready = 2'b00;
        set_slot(0, 2'b00, 4'd9, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, pl_tmp);
        cycle();
        idle();
        for (int h = 0; h < 3; h++) begin
            check("bp_valid", 64'(alu_issue_valid), 2'b01);
            check("bp_occ", 64'(occupancy), 1);
            cycle();
        end
        alu_issue_ready = 2'b11;
        cycle();
        check("bp_freed_occ", 64'(occupancy), 0);
        check("bp_freed_valid", 64'(alu_issue_valid), 0);

        // Fill all 16 entries with ops waiting on tags 16..31
        for (int c = 0; c < 8; c++) begin
            idle();
            check("fill_disp_ready", 64'(disp_ready), 1);
            set_slot(0, 2'b00, 4'(2*c),   6'(16+2*c), 1'b0, 6'd0, 1'b1, 1'b0, fill_pl[2*c]);
            set_slot(1, 2'b00, 4'(2*c+1), 6'(17+2*c), 1'b0, 6'd0, 1'b1, 1'b0, fill_pl[2*c+1]);
            cycle();
        end
        idle();
        check("full_occ", 64'(occupancy), 16);
        check("full_disp_ready", 64'(disp_ready), 0);
        set_slot(0, 2'b00, 4'd15, 6'd1, 1'b1, 6'd1, 1'b1, 1'b0, pl_tmp);
        set_slot(1, 2'b00, 4'd15, 6'd1, 1'b1, 6'd1, 1'b1, 1'b0, pl_tmp);
        cycle();
        idle();
        check("full_ignored_occ", 64'(occupancy), 16);
        check("full_no_issue", 64'(alu_issue_valid), 0);
        alu_q.push_back('{4'd5, fill_pl[5]});
        wk_valid = 2'b01;
        wk_tag   = {6'd0, 6'd21};
        cycle();
        idle();
        check("full_wake5_valid", 64'(alu_issue_valid), 2'b01);
        cycle();
        check("occ15", 64'(occupancy), 15);
        check("occ15_disp_ready", 64'(disp_ready), 0);
        alu_q.push_back('{4'd10, fill_pl[10]});
        wk_valid = 2'b10;
        wk_tag   = {6'd26, 6'd0};
        cycle();
        idle();
        check("full_wake10_valid", 64'(alu_issue_valid), 2'b01);
        cycle();
        check("occ14", 64'(occupancy), 14);
        check("occ14_disp_ready", 64'(disp_ready), 1);
        flush = 1'b1;
        cycle();
        idle();
        check("cleanup_flush_occ", 64'(occupancy), 0);

        // Flush while dispatching 2 ops with 5 waiting entries
        for (int c = 0; c < 3; c++) begin
            idle();
            set_slot(0, 2'(c % 2), 4'(c), 6'(40+2*c), 1'b0, 6'd0, 1'b1, 1'b0, pl_tmp);
            if (c < 2) set_slot(1, 2'b00, 4'(c+8), 6'(41+2*c), 1'b0, 6'd0, 1'b1, 1'b0, pl_tmp);
            cycle();
        end
        idle();
        check("preflush_occ", 64'(occupancy), 5);
        set_slot(0, 2'b00, 4'd1, 6'd1, 1'b1, 6'd1, 1'b1, 1'b0, pl_tmp);
        set_slot(1, 2'b01, 4'd2, 6'd1, 1'b1, 6'd1, 1'b1, 1'b0, pl_tmp);
        wk_valid = 2'b11;
        wk_tag   = {6'd42, 6'd40};
        flush    = 1'b1;
        cycle();
        idle();
        check("flush_occ", 64'(occupancy), 0);
        check("flush_alu_valid", 64'(alu_issue_valid), 0);
        check("flush_mem_valid", 64'(mem_issue_valid), 0);
        check("flush_disp_ready", 64'(disp_ready), 1);
        cycle();
        check("postflush_alu_valid", 64'(alu_issue_valid), 0);

        // Asynchronous reset in the middle of pending issues
        alu_issue_ready = 2'b00;
        set_slot(0, 2'b00, 4'd6, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, pl_tmp);
        set_slot(1, 2'b00, 4'd7, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, pl_tmp);
        cycle();
        idle();
        check("prereset_alu_valid", 64'(alu_issue_valid), 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_alu_valid", 64'(alu_issue_valid), 0);
        check("async_rst_occ", 64'(occupancy), 0);
        check("async_rst_disp_ready", 64'(disp_ready), 1);
        check("async_rst_alu_rob", 64'(alu_issue_rob), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        check("after_rst_occ", 64'(occupancy), 0);

        check("alu_queue_empty", 64'(alu_q.size()), 0);
        check("mem_queue_empty", 64'(mem_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Unified, parametrised reservation station for the out-of-order core. It sits between dispatch/rename and the functional units.
- Accepts up to DISPATCH_WIDTH renamed instructions per cycle and tracks source-tag readiness via wakeup broadcasts.
- Selects ready entries for NUM_ALU ALU issue ports and one MEM issue port, with valid/ready handshakes and full flush support.
- Holds tags and an opaque payload only; operand values are read from the register file at issue.

Parameters:
- RS_DEPTH, 16, number of entries (power of two, >=4).
- DISPATCH_WIDTH, 2, instructions accepted per cycle.
- WAKEUP_PORTS, 2, tag broadcast buses per cycle.
- NUM_ALU, 2, ALU issue ports.
- TAG_W, 6, physical register tag width.
- ROB_SIZE_BITS, 4, ROB index width.
- PAYLOAD_W, 64, opaque decoded-instruction payload width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  DISPATCH_WIDTH  per-slot dispatch valid.
- disp_ready  out  1  all DISPATCH_WIDTH slots can be accepted this cycle.
- disp_src1_tag, disp_src2_tag  in  DISPATCH_WIDTH*TAG_W  source tags.
- disp_src1_rdy, disp_src2_rdy  in  DISPATCH_WIDTH  source ready per rename.
- disp_fu  in  DISPATCH_WIDTH*2  00=ALU, 01=MEM, others illegal.
- disp_rob  in  DISPATCH_WIDTH*ROB_SIZE_BITS  ROB index.
- disp_payload  in  DISPATCH_WIDTH*PAYLOAD_W  payload.
- wk_valid  in  WAKEUP_PORTS  broadcast valid.
- wk_tag  in  WAKEUP_PORTS*TAG_W  produced tag.
- alu_issue_valid  out  NUM_ALU  ALU port has an instruction.
- alu_issue_ready  in  NUM_ALU  ALU accepts.
- alu_issue_rob, alu_issue_payload, alu_issue_src1_tag, alu_issue_src2_tag  out  per-port widths  issued entry fields.
- mem_issue_valid  out  1; mem_issue_ready  in  1.
- mem_issue_rob, mem_issue_payload, mem_issue_src1_tag, mem_issue_src2_tag  out  issued MEM entry fields.
- occupancy  out  $clog2(RS_DEPTH)+1  valid entry count.

Behaviour:
- Reset (rst_n low, async):
  - All entry valid bits are cleared.
  - occupancy=0, disp_ready=1, all issue_valid=0, issue data outputs=0.
- Entry state: valid, src1_rdy, src2_rdy, src tags, fu, rob, payload.
- Ready rule: an entry is ready when valid and both rdy bits are set. Tag 0 is always treated as ready.
- Dispatch:
  - A slot is accepted when disp_valid[i] && disp_ready && !flush.
  - Accepted slots fill the lowest-index free entries, in slot order.
  - disp_ready = (RS_DEPTH - occupancy) >= DISPATCH_WIDTH. It is computed from registered occupancy; freed entries count from the next cycle.
- Wakeup:
  - A valid wk_tag equal to an entry's tag sets that entry's rdy bit on the next edge.
  - Wakeup also applies to instructions dispatched in the same cycle (dispatch-wakeup bypass).
  - wk_tag==0 is ignored.
- Issue selection (combinational from registered state):
  - ALU port k presents the k-th lowest-index ready ALU entry.
  - The MEM port presents the lowest-index ready MEM entry.
  - An entry is never presented on two ports.
  - A newly dispatched entry can issue no earlier than the cycle after dispatch. A woken entry can issue the cycle after the wakeup.
- Handshake:
  - An entry is freed at the edge where valid&&ready on its port.
  - A not-accepted entry stays selected unless a lower-index entry of its class becomes ready. Re-selection is allowed; outputs need not be held stable.
- Occupancy: next = occupancy + accepted dispatches - issued.
- Flush:
  - At the next edge all valids are cleared and occupancy=0.
  - Same-cycle dispatches and issue handshakes are discarded.
  - Wakeups in the flush cycle have no effect.
- Full: disp_ready=0; disp_valid is ignored. Overflow is impossible by construction.
- Empty: all issue_valid=0.
- Illegal disp_fu (1x): the entry is accepted but never issues. This is an assertion in simulation only.
- Mid-operation reset: async clear as above, regardless of pending handshakes.

Decomposition:
- Shared package (ooo_pkg):
  - Constants: ROB_SIZE_BITS, TAG_W, fu encoding (FU_ALU, FU_MEM).
  - Typedefs: rs_entry_t (packed version of the existing reservation station entry), wakeup_t {valid, tag}, issue_t {valid, rob, tags, payload}.
- Sub-module rs_pick_n:
  - Parametrised N-of-M lowest-index priority picker over a request vector.
  - Outputs one-hot grants per port.
  - Used for free-slot allocation (N=DISPATCH_WIDTH), ALU issue (N=NUM_ALU) and MEM issue (N=1).

Test Plan:
- Reset then dispatch 2 ALU ops with rdy=1,1, rob 3,4 -> next cycle alu_issue_valid=2'b11 with rob 3 on port0 and 4 on port1; occupancy 2->0 after ready; the cycle after, all valid=0.
- Dispatch MEM op src1_tag=9 not ready; hold 5 cycles with mem_issue_valid=0; wk_tag=9 -> mem_issue_valid=1 the following cycle.
- Same-cycle bypass: dispatch src2_tag=12 rdy=0 while wk_tag=12 is valid -> entry is issuable the next cycle.
- Fill 16 entries with unready ops -> occupancy=16, disp_ready=0 at 15 entries; wake one and issue it -> disp_ready stays 0 (15 left, needs 2 free); issue one more -> disp_ready=1.
- Backpressure: ready ALU entry with alu_issue_ready=0 for 3 cycles -> entry retained, occupancy unchanged; ready=1 -> freed.
- flush asserted during dispatch of 2 ops with 5 valid entries -> next cycle occupancy=0, no issue_valid; async rst_n pulse mid-stream -> outputs zero immediately.
